// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART between NUM_REQ requesters.
// One transfer in flight: launch, wait for result or timeout, respond.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int LAUNCH_CYCLES = 2,
    parameter int TIMEOUT       = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [7*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [6:0]             uart_data,
    output logic                   uart_in_ready,
    input  logic [7:0]             uart_data_out,
    input  logic                   uart_out_valid,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   rsp_error,
    output logic                   busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int LW = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t              state, state_d;
    logic [GW-1:0]       grant, grant_d;
    logic [GW-1:0]       last_grant, last_d;
    logic [LW-1:0]       lcnt, lcnt_d;
    logic [TW-1:0]       wcnt, wcnt_d;
    logic [NUM_REQ-1:0]  ack_d;
    logic [6:0]          data_d;
    logic                rdy_d;
    logic [NUM_REQ-1:0]  rv_d;
    logic [7:0]          rd_d;
    logic                re_d;
    logic                busy_d;

    logic [6:0]          words [NUM_REQ];
    logic                found;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[7*i +: 7];
        end
    end

    // Search starts just past the previous winner and wraps.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        last_d  = last_grant;
        lcnt_d  = lcnt;
        wcnt_d  = wcnt;
        ack_d   = '0;
        data_d  = uart_data;
        rdy_d   = uart_in_ready;
        rv_d    = '0;
        rd_d    = rsp_data;
        re_d    = rsp_error;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d     = LAUNCH;
                    grant_d     = pick;
                    last_d      = pick;
                    lcnt_d      = '0;
                    ack_d[pick] = 1'b1;
                    data_d      = words[pick];
                    rdy_d       = 1'b1;
                end
            end
            LAUNCH: begin
                if (lcnt == LW'(LAUNCH_CYCLES - 1)) begin
                    state_d = WAIT;
                    rdy_d   = 1'b0;
                    wcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt + 1'b1;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (uart_out_valid) begin
                    state_d     = RESP;
                    rd_d        = uart_data_out;
                    re_d        = 1'b0;
                    rv_d[grant] = 1'b1;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rd_d        = '0;
                    re_d        = 1'b1;
                    rv_d[grant] = 1'b1;
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= GW'(NUM_REQ - 1);
            lcnt          <= '0;
            wcnt          <= '0;
            req_ack       <= '0;
            uart_data     <= '0;
            uart_in_ready <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_error     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_d;
            lcnt          <= lcnt_d;
            wcnt          <= wcnt_d;
            req_ack       <= ack_d;
            uart_data     <= data_d;
            uart_in_ready <= rdy_d;
            rsp_valid     <= rv_d;
            rsp_data      <= rd_d;
            rsp_error     <= re_d;
            busy          <= busy_d;
        end
    end

endmodule
